// File: rtl/dec_uart_tx_pkg.sv
// Shared constants, serializer state encoding and line buffer type for the
// decimal-to-UART line transmitter.
package dec_uart_tx_pkg;

    localparam logic [7:0] ASCII_ZERO = 8'h30;
    localparam logic [7:0] ASCII_CR   = 8'h0D;
    localparam logic [7:0] ASCII_LF   = 8'h0A;

    localparam int unsigned LINE_MAX  = 5;
    localparam int unsigned IDX_W     = 3;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START_BIT = 2'd1,
        DATA_BITS = 2'd2,
        STOP_BIT  = 2'd3
    } tx_state_e;

    // Element 0 is the first byte on the wire.
    typedef logic [LINE_MAX-1:0][7:0] line_t;

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer. o_ready is high in IDLE and in the final cycle of a
// stop bit, so a byte offered then starts its start bit with no idle gap.
module uart_tx_byte
    import dec_uart_tx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 234
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_valid,
    input  logic [7:0] i_data,
    output logic       o_ready,
    output logic       o_tx
);

    localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    tx_state_e         state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [2:0]        bit_q, bit_d;
    logic [7:0]        shift_q, shift_d;
    logic              tx_q, tx_d;
    logic              ready_q, ready_d;
    logic              baud_last;

    assign baud_last = (baud_q == BAUD_LAST);

    // Next-state logic; ready is computed one cycle ahead so it is registered.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (i_valid) begin
                    state_d = START_BIT;
                    shift_d = i_data;
                    tx_d    = 1'b0;
                    baud_d  = '0;
                    bit_d   = '0;
                end
            end
            START_BIT: begin
                if (baud_last) begin
                    state_d = DATA_BITS;
                    baud_d  = '0;
                    tx_d    = shift_q[0];
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            DATA_BITS: begin
                if (baud_last) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = STOP_BIT;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shift_d = {1'b0, shift_q[7:1]};
                        tx_d    = shift_q[1];
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            STOP_BIT: begin
                if (baud_last) begin
                    baud_d = '0;
                    if (i_valid) begin
                        state_d = START_BIT;
                        shift_d = i_data;
                        tx_d    = 1'b0;
                        bit_d   = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        ready_d = (state_d == IDLE) || ((state_d == STOP_BIT) && (baud_d == BAUD_LAST));
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            ready_q <= ready_d;
        end
    end

    assign o_ready = ready_q;
    assign o_tx    = tx_q;

endmodule

// File: rtl/dec_uart_tx.sv
// Line sequencer: latches three ASCII digits, drops leading zeros if enabled,
// and streams "digits CR LF" through uart_tx_byte.
module dec_uart_tx
    import dec_uart_tx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT   = 234,
    parameter bit          SUPPRESS_ZEROS = 1'b1
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [7:0] i_hundreds,
    input  logic [7:0] i_tens,
    input  logic [7:0] i_units,
    input  logic       i_start,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_tx
);

    logic             busy_q, done_q;
    line_t            line_q, line_c;
    logic [IDX_W-1:0] len_q, len_c, idx_q;
    logic             skip_h_c, skip_t_c;
    logic             accept_c, handoff_c, finish_c;
    logic             byte_valid_c, ser_ready;
    logic [7:0]       byte_data_c, cur_byte_c;

    // Compact the line so suppressed digits leave no hole in the buffer.
    always_comb begin
        skip_h_c = SUPPRESS_ZEROS && (i_hundreds == ASCII_ZERO);
        skip_t_c = skip_h_c && (i_tens == ASCII_ZERO);
        line_c   = {ASCII_LF, ASCII_CR, i_units, i_tens, i_hundreds};
        len_c    = IDX_W'(5);
        if (skip_t_c) begin
            line_c = {8'h00, 8'h00, ASCII_LF, ASCII_CR, i_units};
            len_c  = IDX_W'(3);
        end else if (skip_h_c) begin
            line_c = {8'h00, ASCII_LF, ASCII_CR, i_units, i_tens};
            len_c  = IDX_W'(4);
        end
    end

    always_comb begin
        cur_byte_c = 8'h00;
        case (idx_q)
            3'd0:    cur_byte_c = line_q[0];
            3'd1:    cur_byte_c = line_q[1];
            3'd2:    cur_byte_c = line_q[2];
            3'd3:    cur_byte_c = line_q[3];
            3'd4:    cur_byte_c = line_q[4];
            default: cur_byte_c = 8'h00;
        endcase
    end

    // First byte goes straight from the inputs so the start bit begins next cycle.
    assign accept_c     = i_start && !busy_q;
    assign handoff_c    = busy_q && ser_ready && (idx_q < len_q);
    assign finish_c     = busy_q && ser_ready && (idx_q == len_q);
    assign byte_valid_c = accept_c || (busy_q && (idx_q < len_q));
    assign byte_data_c  = accept_c ? line_c[0] : cur_byte_c;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            busy_q <= 1'b0;
            done_q <= 1'b0;
            line_q <= '0;
            len_q  <= '0;
            idx_q  <= '0;
        end else begin
            done_q <= finish_c;
            if (accept_c) begin
                busy_q <= 1'b1;
                line_q <= line_c;
                len_q  <= len_c;
                idx_q  <= IDX_W'(1);
            end else if (handoff_c) begin
                idx_q <= idx_q + IDX_W'(1);
            end else if (finish_c) begin
                busy_q <= 1'b0;
            end
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tx_byte (
        .i_clk  (i_clk),
        .i_rst_n(i_rst_n),
        .i_valid(byte_valid_c),
        .i_data (byte_data_c),
        .o_ready(ser_ready),
        .o_tx   (o_tx)
    );

    assign o_busy = busy_q;
    assign o_done = done_q;

endmodule

// File: tb/tb_dec_uart_tx.sv
// Scoreboard bench: one DUT with zero suppression, one without; a UART
// receiver per DUT decodes frames and checks them against queued lines.
module tb_dec_uart_tx;

    localparam int CPB   = 4;
    localparam int FRAME = 10 * CPB;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] hund, tens, units;
    logic       start_a, start_b;
    logic       busy_a, done_a, tx_a;
    logic       busy_b, done_b, tx_b;

    int         vectors = 0;
    int         errors  = 0;
    int         cyc     = 0;
    int         rst_count = 0;

    logic [7:0] exp_a[$];
    logic [7:0] exp_b[$];
    int         lines_a[$];
    int         lines_b[$];
    bit         act_a = 1'b0;
    bit         act_b = 1'b0;
    int         t0_a = 0;
    int         t0_b = 0;

    dec_uart_tx #(.CLKS_PER_BIT(CPB), .SUPPRESS_ZEROS(1'b1)) dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_hundreds(hund), .i_tens(tens), .i_units(units),
        .i_start(start_a), .o_busy(busy_a), .o_done(done_a), .o_tx(tx_a)
    );

    dec_uart_tx #(.CLKS_PER_BIT(CPB), .SUPPRESS_ZEROS(1'b0)) dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_hundreds(hund), .i_tens(tens), .i_units(units),
        .i_start(start_b), .o_busy(busy_b), .o_done(done_b), .o_tx(tx_b)
    );

    initial forever #5 clk = ~clk;
    initial forever begin @(posedge clk); cyc++; end
    initial forever begin @(negedge rst_n); rst_count++; end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, wanted 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic flag(input string name, input string what);
        vectors++;
        errors++;
        $display("FAIL %s: %s (cycle %0d)", name, what, cyc);
    endtask

    // Reference: digits, leading '0's stripped (never the units) when suppressing, then CR LF.
    task automatic push_line(input bit which, input logic [7:0] h, input logic [7:0] t,
                             input logic [7:0] u);
        logic [7:0] q[$];
        q = {h, t, u};
        if (!which)
            while (q.size() > 1 && q[0] == 8'h30) q.delete(0);
        q.push_back(8'h0D);
        q.push_back(8'h0A);
        foreach (q[i]) begin
            if (which) exp_b.push_back(q[i]);
            else       exp_a.push_back(q[i]);
        end
        if (which) lines_b.push_back(q.size());
        else       lines_a.push_back(q.size());
    endtask

    function automatic logic txv(input bit which);
        return which ? tx_b : tx_a;
    endfunction

    // Called on the negedge of the first low cycle; samples each bit mid-cell.
    task automatic rx_frame(input bit which, output logic [7:0] data, output bit ok);
        int   snap;
        int   j;
        logic b;
        snap = rst_count;
        ok   = 1'b1;
        data = '0;
        for (int k = 1; k <= CPB / 2 + 9 * CPB; k++) begin
            @(negedge clk);
            if (rst_count != snap) begin
                ok = 1'b0;
                return;
            end
            if ((k >= CPB / 2) && ((k - CPB / 2) % CPB == 0)) begin
                j = (k - CPB / 2) / CPB;
                b = txv(which);
                if (j == 0)      check(which ? "start_bit_b" : "start_bit_a", 32'(b), 32'd0);
                else if (j == 9) check(which ? "stop_bit_b" : "stop_bit_a", 32'(b), 32'd1);
                else             data[j-1] = b;
            end
        end
    endtask

    initial begin : mon_bytes_a
        logic [7:0] d;
        bit         ok;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && tx_a === 1'b0) begin
                if (!act_a) begin act_a = 1'b1; t0_a = cyc; end
                rx_frame(1'b0, d, ok);
                if (ok) begin
                    if (exp_a.size() == 0) flag("byte_a", "unexpected frame");
                    else check("byte_a", 32'(d), 32'(exp_a.pop_front()));
                end
            end
        end
    end

    initial begin : mon_bytes_b
        logic [7:0] d;
        bit         ok;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && tx_b === 1'b0) begin
                if (!act_b) begin act_b = 1'b1; t0_b = cyc; end
                rx_frame(1'b1, d, ok);
                if (ok) begin
                    if (exp_b.size() == 0) flag("byte_b", "unexpected frame");
                    else check("byte_b", 32'(d), 32'(exp_b.pop_front()));
                end
            end
        end
    end

    initial forever begin : mon_done_a
        @(negedge clk);
        if (rst_n === 1'b1 && done_a === 1'b1) begin
            check("busy_at_done_a", 32'(busy_a), 32'd0);
            if (lines_a.size() == 0) flag("done_a", "unexpected o_done");
            else check("done_time_a", 32'(cyc - t0_a), 32'(lines_a.pop_front() * FRAME));
            act_a = 1'b0;
        end
    end

    initial forever begin : mon_done_b
        @(negedge clk);
        if (rst_n === 1'b1 && done_b === 1'b1) begin
            check("busy_at_done_b", 32'(busy_b), 32'd0);
            if (lines_b.size() == 0) flag("done_b", "unexpected o_done");
            else check("done_time_b", 32'(cyc - t0_b), 32'(lines_b.pop_front() * FRAME));
            act_b = 1'b0;
        end
    end

    task automatic wait_done(input bit which);
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if ((which ? done_b : done_a) === 1'b1) return;
        end
        flag(which ? "wait_done_b" : "wait_done_a", "timeout waiting for o_done");
    endtask

    // Must be called between clock edges; returns 1 time unit after the sampling edge.
    task automatic send(input bit which, input logic [7:0] h, input logic [7:0] t,
                        input logic [7:0] u, input bit hold);
        hund  = h;
        tens  = t;
        units = u;
        push_line(which, h, t, u);
        if (which) start_b = 1'b1;
        else       start_a = 1'b1;
        @(posedge clk);
        #1;
        check(which ? "latency_tx_b" : "latency_tx_a", 32'(txv(which)), 32'd0);
        check(which ? "latency_busy_b" : "latency_busy_a", 32'(which ? busy_b : busy_a), 32'd1);
        if (!hold) begin
            start_a = 1'b0;
            start_b = 1'b0;
        end
    endtask

    task automatic poke_a(input logic [7:0] h, input logic [7:0] t, input logic [7:0] u);
        hund    = h;
        tens    = t;
        units   = u;
        start_a = 1'b1;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        check("busy_during_poke_a", 32'(busy_a), 32'd1);
    endtask

    function automatic logic [7:0] rnd_char();
        int unsigned r;
        r = $urandom_range(0, 9);
        if (r < 4)  return 8'h30;
        if (r == 9) return 8'($urandom_range(0, 255));
        return 8'(32'h30 + $urandom_range(1, 9));
    endfunction

    initial begin : stim
        rst_n   = 1'b0;
        start_a = 1'b0;
        start_b = 1'b0;
        hund    = 8'h30;
        tens    = 8'h30;
        units   = 8'h30;
        repeat (3) @(posedge clk);
        #1;
        check("rst_tx_a", 32'(tx_a), 32'd1);
        check("rst_busy_a", 32'(busy_a), 32'd0);
        check("rst_done_a", 32'(done_a), 32'd0);
        check("rst_tx_b", 32'(tx_b), 32'd1);
        check("rst_busy_b", 32'(busy_b), 32'd0);
        check("rst_done_b", 32'(done_b), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        send(1'b0, "1", "2", "8", 1'b0);
        wait_done(1'b0);
        send(1'b0, "0", "0", "7", 1'b0);
        wait_done(1'b0);
        @(negedge clk);
        send(1'b0, "0", "4", "0", 1'b0);
        wait_done(1'b0);
        send(1'b1, "0", "0", "7", 1'b0);
        wait_done(1'b1);
        send(1'b1, "1", "2", "8", 1'b0);
        wait_done(1'b1);

        // Start pulse during byte 2 must not disturb the line or queue another.
        @(negedge clk);
        send(1'b0, "5", "6", "7", 1'b0);
        repeat (45) @(negedge clk);
        poke_a("9", "9", "9");
        wait_done(1'b0);
        repeat (60) @(negedge clk);
        check("idle_tx_after_poke", 32'(tx_a), 32'd1);
        check("idle_busy_after_poke", 32'(busy_a), 32'd0);
        check("queue_empty_after_poke", 32'(exp_a.size()), 32'd0);

        // Reset during data bit 3 of 0x37 (a zero bit), then restart immediately.
        send(1'b0, "0", "0", "7", 1'b0);
        repeat (16) @(posedge clk);
        #1;
        check("pre_reset_tx_a", 32'(tx_a), 32'd0);
        rst_n = 1'b0;
        #1;
        check("async_rst_tx_a", 32'(tx_a), 32'd1);
        check("async_rst_busy_a", 32'(busy_a), 32'd0);
        check("async_rst_done_a", 32'(done_a), 32'd0);
        exp_a.delete();
        lines_a.delete();
        act_a = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        send(1'b0, "2", "0", "0", 1'b0);
        wait_done(1'b0);

        // Start held across o_done: second line starts right after the done cycle.
        @(negedge clk);
        push_line(1'b0, "3", "0", "5");
        send(1'b0, "3", "0", "5", 1'b1);
        wait_done(1'b0);
        check("done_cycle_tx_a", 32'(tx_a), 32'd1);
        @(posedge clk);
        #1;
        check("b2b_tx_a", 32'(tx_a), 32'd0);
        check("b2b_busy_a", 32'(busy_a), 32'd1);
        start_a = 1'b0;
        wait_done(1'b0);

        for (int n = 0; n < 30; n++) begin
            if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 4)) @(negedge clk);
            send(1'b0, rnd_char(), rnd_char(), rnd_char(), 1'b0);
            if ($urandom_range(0, 2) == 0) begin
                repeat ($urandom_range(2, 100)) @(negedge clk);
                poke_a(rnd_char(), rnd_char(), rnd_char());
            end
            wait_done(1'b0);
        end

        for (int n = 0; n < 6; n++) begin
            if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 4)) @(negedge clk);
            send(1'b1, rnd_char(), rnd_char(), rnd_char(), 1'b0);
            wait_done(1'b1);
        end

        repeat (50) @(negedge clk);
        check("final_bytes_a", 32'(exp_a.size()), 32'd0);
        check("final_bytes_b", 32'(exp_b.size()), 32'd0);
        check("final_lines_a", 32'(lines_a.size()), 32'd0);
        check("final_lines_b", 32'(lines_b.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
